mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, 1-cycle-read-latency 32-bit memory (codemem/datamem
//  class) between two requesters: port A (CPU pipeline) and port B (UART loader/DMA).
//  Fixed priority to A, with a starvation limit that forces a grant to B.
//  Sits between the requesters and the memory macro; returns read data tagged to the winner.
// PARAMETERS
//  AW        13  word-address width (memory depth = 2**AW words)
//  MAX_WAIT  8   cycles B may be refused while requesting before B is forced (1..255)
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   synchronous reset, active high
//  a_valid    in   1   A request (read or write)
//  a_write    in   1   A request is write
//  a_wmask    in   4   A byte enables (bit n -> wdata[8n+7:8n])
//  a_wdata    in   32  A write data
//  a_addr     in   AW  A word address
//  a_ready    out  1   A request accepted this cycle (comb)
//  a_rvalid   out  1   A read data valid (cycle after accepted read)
//  a_rdata    out  32  A read data
//  b_*        --   --  same eight signals for port B
//  mem_valid  out  1   access issued to memory this cycle
//  mem_write  out  1   issued access is write
//  mem_wmask  out  4   byte enables to memory
//  mem_wdata  out  32  write data to memory
//  mem_addr   out  AW  word address to memory
//  mem_rdata  in   32  memory read data, valid one cycle after the read is issued
// BEHAVIOUR
//  - Grant (comb): A only -> A; B only -> B; both -> B if wait_cnt==MAX_WAIT, else A.
//    During rst: a_ready=b_ready=0, mem_valid=0.
//  - x_ready = x_valid & granted(x). One access per cycle; at most one ready high.
//  - Mem mux: mem_valid = a_ready|b_ready; mem_write/wmask/wdata/addr from winner;
//    idle cycle drives mem_write=0, mem_wmask=0, others from A (don't-care).
//  - Requester holds valid/write/wmask/wdata/addr stable until its ready; dropping or
//    changing before ready is a protocol error (bench asserts, RTL need not detect).
//  - wait_cnt (8 bit): +1 when b_valid & ~b_ready, saturating at MAX_WAIT;
//    cleared when b_ready or ~b_valid. Reset 0.
//  - Read return: q_rd_a <= a_ready & ~a_write; q_rd_b <= b_ready & ~b_write.
//    a_rvalid=q_rd_a, b_rvalid=q_rd_b (latency exactly 1 cycle after ready).
//    a_rdata=b_rdata=mem_rdata (unqualified; only meaningful with x_rvalid).
//  - Writes complete at the ready cycle; no rvalid for writes.
//  - Back-to-back: a new grant may occur in the same cycle as a prior read's rvalid.
//  - Simultaneous A/B to the same address: serialised; winner's access strictly first,
//    loser sees memory state after winner's write.
//  - Reset mid-operation: q_rd_a/q_rd_b cleared, so a read accepted in the cycle before
//    rst is asserted yields no rvalid; wait_cnt=0.
//  - Reset values: a_ready=b_ready=0, a_rvalid=b_rvalid=0, mem_valid=0, mem_write=0.
//  - Worst-case B latency to grant: MAX_WAIT+1 cycles under continuous A traffic.
// TESTING
//  1 A-only: A read addr 0x10 (mem preloaded 0xDEADBEEF) -> a_ready same cycle,
//    a_rvalid next cycle, a_rdata=0xDEADBEEF, b_rvalid stays 0.
//  2 Contention: A and B both valid continuously, MAX_WAIT=8 -> A granted 8 cycles,
//    B granted on cycle 9, then A 8 more, B again (pattern repeats).
//  3 Byte write: B write addr 3, wmask=4'b0100, wdata=0x00AB0000 over 0x11223344 ->
//    A read addr 3 returns 0x11AB3344.
//  4 Same-address race: A write 0xCAFEF00D, B read addr 5 same cycle, wait_cnt<MAX_WAIT
//    -> A granted first, B granted next cycle, b_rdata=0xCAFEF00D.
//  5 Reset mid-read: A read accepted, rst high next cycle -> a_rvalid=0, mem_valid=0,
//    wait_cnt=0; after rst low, first request granted normally.
//  6 Saturation: B refused MAX_WAIT cycles, then B drops valid -> wait_cnt clears to 0;
//    B re-requests with A busy -> waits full MAX_WAIT again.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester ports A/B and the memory bus of the arbiter
interface mem_port_arbiter_if #(parameter int AW = 13);
  logic          a_valid, a_write, a_ready, a_rvalid;
  logic [3:0]    a_wmask;
  logic [31:0]   a_wdata, a_rdata;
  logic [AW-1:0] a_addr;
  logic          b_valid, b_write, b_ready, b_rvalid;
  logic [3:0]    b_wmask;
  logic [31:0]   b_wdata, b_rdata;
  logic [AW-1:0] b_addr;
  logic          mem_valid, mem_write;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  modport master (
    output a_valid, a_write, a_wmask, a_wdata, a_addr,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_write, b_wmask, b_wdata, b_addr,
    input  b_ready, b_rvalid, b_rdata,
    input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    output mem_rdata
  );
  modport slave (
    input  a_valid, a_write, a_wmask, a_wdata, a_addr,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_write, b_wmask, b_wdata, b_addr,
    output b_ready, b_rvalid, b_rdata,
    output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-priority A/B arbiter for a 1-cycle-latency memory with B starvation limit
module mem_port_arbiter #(
  parameter int AW = 13,
  parameter int MAX_WAIT = 8
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  logic [7:0] wait_cnt;
  logic q_rd_a, q_rd_b, pick_b;
  // grant selection and memory mux; B wins when alone or when its wait has saturated
  always_comb begin
    pick_b = bus.b_valid & (~bus.a_valid | (wait_cnt == 8'(MAX_WAIT)));
    bus.a_ready = ~rst & bus.a_valid & ~pick_b;
    bus.b_ready = ~rst & pick_b;
    bus.mem_valid = bus.a_ready | bus.b_ready;
    bus.mem_write = bus.b_ready ? bus.b_write : bus.a_ready & bus.a_write;
    bus.mem_wmask = bus.b_ready ? bus.b_wmask : bus.a_ready ? bus.a_wmask : 4'b0;
    bus.mem_wdata = bus.b_ready ? bus.b_wdata : bus.a_wdata;
    bus.mem_addr = bus.b_ready ? bus.b_addr : bus.a_addr;
    bus.a_rvalid = q_rd_a & ~rst;
    bus.b_rvalid = q_rd_b & ~rst;
    bus.a_rdata = bus.mem_rdata;
    bus.b_rdata = bus.mem_rdata;
  end
  // starvation counter and read-return tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'd0;
      q_rd_a <= 1'b0;
      q_rd_b <= 1'b0;
    end else begin
      wait_cnt <= (bus.b_ready | ~bus.b_valid) ? 8'd0 :
                  (wait_cnt == 8'(MAX_WAIT)) ? wait_cnt : wait_cnt + 8'd1;
      q_rd_a <= bus.a_ready & ~bus.a_write;
      q_rd_b <= bus.b_ready & ~bus.b_write;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant, starvation, byte writes, read return and reset
module tb_mem_port_arbiter;
  localparam int AW = 13;
  localparam int MW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] mem [0:(1<<AW)-1];
  mem_port_arbiter_if #(.AW(AW)) bus ();
  mem_port_arbiter #(.AW(AW), .MAX_WAIT(MW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // single-ported memory model with byte enables and 1-cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      mem[16] <= 32'hDEADBEEF;
      mem[3] <= 32'h11223344;
      mem[5] <= 32'h0;
    end else if (bus.mem_valid) begin
      if (bus.mem_write) begin
        for (int n = 0; n < 4; n++)
          if (bus.mem_wmask[n]) mem[bus.mem_addr][8*n+:8] <= bus.mem_wdata[8*n+:8];
      end else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end
  a_hold: assert property (@(posedge clk) disable iff (rst)
    bus.a_valid && !bus.a_ready |=> bus.a_valid &&
    $stable({bus.a_write, bus.a_wmask, bus.a_wdata, bus.a_addr}));
  b_hold: assert property (@(posedge clk) disable iff (rst)
    bus.b_valid && !bus.b_ready |=> !bus.b_valid ||
    $stable({bus.b_write, bus.b_wmask, bus.b_wdata, bus.b_addr}));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.a_valid = 1'b0; bus.a_write = 1'b0; bus.a_wmask = 4'h0; bus.a_wdata = 32'h0; bus.a_addr = '0;
    bus.b_valid = 1'b0; bus.b_write = 1'b0; bus.b_wmask = 4'h0; bus.b_wdata = 32'h0; bus.b_addr = '0;
  endtask
  task automatic a_req(input logic w, input logic [3:0] m, input logic [31:0] d, input logic [AW-1:0] ad);
    bus.a_valid = 1'b1; bus.a_write = w; bus.a_wmask = m; bus.a_wdata = d; bus.a_addr = ad;
  endtask
  task automatic b_req(input logic w, input logic [3:0] m, input logic [31:0] d, input logic [AW-1:0] ad);
    bus.b_valid = 1'b1; bus.b_write = w; bus.b_wmask = m; bus.b_wdata = d; bus.b_addr = ad;
  endtask
  task automatic drain_a;
    bus.b_valid = 1'b0;
    #1;
    check("drain_a_ready", 32'(bus.a_ready), 32'd1);
    tick;
    idle;
  endtask
  task automatic contend(input string tag, input int cycles, input int b_at);
    for (int i = 0; i < cycles; i++) begin
      #1;
      check({tag, "_a_ready"}, 32'(bus.a_ready), 32'(i != b_at));
      check({tag, "_b_ready"}, 32'(bus.b_ready), 32'(i == b_at));
      tick;
    end
  endtask
  initial begin
    idle;
    a_req(1'b0, 4'h0, 32'h0, 13'd16);
    b_req(1'b1, 4'hF, 32'h0, 13'd16);
    tick;
    #1;
    check("rst_a_ready", 32'(bus.a_ready), 32'd0);
    check("rst_b_ready", 32'(bus.b_ready), 32'd0);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    check("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
    tick;
    idle;
    rst = 1'b0;
    tick;
    a_req(1'b0, 4'h0, 32'h0, 13'd16);
    #1;
    check("t1_a_ready", 32'(bus.a_ready), 32'd1);
    check("t1_b_ready", 32'(bus.b_ready), 32'd0);
    check("t1_mem_valid", 32'(bus.mem_valid), 32'd1);
    check("t1_mem_addr", 32'(bus.mem_addr), 32'd16);
    check("t1_mem_write", 32'(bus.mem_write), 32'd0);
    tick;
    idle;
    #1;
    check("t1_a_rvalid", 32'(bus.a_rvalid), 32'd1);
    check("t1_a_rdata", bus.a_rdata, 32'hDEADBEEF);
    check("t1_b_rvalid", 32'(bus.b_rvalid), 32'd0);
    check("t1_idle_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("t1_idle_mem_wmask", 32'(bus.mem_wmask), 32'd0);
    tick;
    check("t1_a_rvalid_drop", 32'(bus.a_rvalid), 32'd0);
    a_req(1'b0, 4'h0, 32'h0, 13'd16);
    b_req(1'b0, 4'h0, 32'h0, 13'd3);
    for (int i = 0; i < 2*(MW+1); i++) begin
      #1;
      check("t2_a_ready", 32'(bus.a_ready), 32'(i % (MW+1) != MW));
      check("t2_b_ready", 32'(bus.b_ready), 32'(i % (MW+1) == MW));
      check("t2_b_rvalid", 32'(bus.b_rvalid), 32'(i == MW+1));
      tick;
    end
    check("t2_b_rvalid_end", 32'(bus.b_rvalid), 32'd1);
    check("t2_b_rdata_end", bus.b_rdata, 32'h11223344);
    drain_a;
    b_req(1'b1, 4'b0100, 32'h00AB0000, 13'd3);
    #1;
    check("t3_b_ready", 32'(bus.b_ready), 32'd1);
    check("t3_mem_write", 32'(bus.mem_write), 32'd1);
    check("t3_mem_wmask", 32'(bus.mem_wmask), 32'b0100);
    tick;
    idle;
    a_req(1'b0, 4'h0, 32'h0, 13'd3);
    #1;
    check("t3_a_ready", 32'(bus.a_ready), 32'd1);
    check("t3_b_rvalid_write", 32'(bus.b_rvalid), 32'd0);
    tick;
    idle;
    #1;
    check("t3_a_rvalid", 32'(bus.a_rvalid), 32'd1);
    check("t3_a_rdata", bus.a_rdata, 32'h11AB3344);
    tick;
    a_req(1'b1, 4'hF, 32'hCAFEF00D, 13'd5);
    b_req(1'b0, 4'h0, 32'h0, 13'd5);
    #1;
    check("t4_a_ready", 32'(bus.a_ready), 32'd1);
    check("t4_b_ready", 32'(bus.b_ready), 32'd0);
    tick;
    bus.a_valid = 1'b0;
    #1;
    check("t4_b_ready_next", 32'(bus.b_ready), 32'd1);
    check("t4_mem_addr", 32'(bus.mem_addr), 32'd5);
    check("t4_a_rvalid_write", 32'(bus.a_rvalid), 32'd0);
    tick;
    idle;
    #1;
    check("t4_b_rvalid", 32'(bus.b_rvalid), 32'd1);
    check("t4_b_rdata", bus.b_rdata, 32'hCAFEF00D);
    tick;
    a_req(1'b0, 4'h0, 32'h0, 13'd16);
    b_req(1'b0, 4'h0, 32'h0, 13'd16);
    contend("t5_pre", 3, -1);
    rst = 1'b1;
    #1;
    check("t5_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    check("t5_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("t5_a_ready", 32'(bus.a_ready), 32'd0);
    tick;
    check("t5_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    rst = 1'b0;
    contend("t5_post", MW+1, MW);
    drain_a;
    a_req(1'b0, 4'h0, 32'h0, 13'd16);
    b_req(1'b0, 4'h0, 32'h0, 13'd16);
    contend("t6_starve", MW, -1);
    check("t6_wait_sat", 32'(dut.wait_cnt), 32'(MW));
    bus.b_valid = 1'b0;
    #1;
    check("t6_drop_a_ready", 32'(bus.a_ready), 32'd1);
    tick;
    check("t6_wait_clr", 32'(dut.wait_cnt), 32'd0);
    b_req(1'b0, 4'h0, 32'h0, 13'd16);
    contend("t6_again", MW+1, MW);
    drain_a;
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
